// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states and line levels.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO with first-word-fall-through dout and registered full/empty/count.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt
);
  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;

  // Caller qualifies push/pop; both in one cycle leave the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  assign dout      = mem[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

// File: rtl/uart_tx_io.sv
// IO-space UART transmitter: queues CPU writes and shifts them out as 8N1, LSB first.
module uart_tx_io #(
  parameter int CLKS_PER_BIT = 200,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             clr_ovf,
  output logic             tx,
  output logic             busy,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic [1:0]       state_dbg
);
  import uart_pkg::*;

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_e        state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             busy_q, ovf_q, ovf_d;
  logic             baud_last, fifo_push, fifo_pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count, fifo_count_nxt;

  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
  // Pop in IDLE, or on the last STOP cycle so frames run back-to-back.
  assign fifo_pop  = !fifo_empty &&
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_last));
  // A simultaneous pop frees a slot, so a write while full still lands.
  assign fifo_push = wr_en && (!fifo_full || fifo_pop);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .din       (wr_data),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .count_nxt (fifo_count_nxt)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          shreg_d = fifo_dout;
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else baud_d = baud_q + 1'b1;
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
          else                            bit_d   = bit_q + 1'b1;
        end else baud_d = baud_q + 1'b1;
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (fifo_pop) begin
            shreg_d = fifo_dout;
            state_d = ST_START;
          end else state_d = ST_IDLE;
        end else baud_d = baud_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the next state so tx is a clean register output.
  always_comb begin
    tx_d = IDLE_LVL;
    case (state_d)
      ST_START: tx_d = START_LVL;
      ST_DATA:  tx_d = shreg_d[0];
      ST_STOP:  tx_d = STOP_LVL;
      default:  tx_d = IDLE_LVL;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && !fifo_push) ovf_d = 1'b1;
    else if (clr_ovf)        ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= IDLE_LVL;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != ST_IDLE) || (fifo_count_nxt != '0);
      ovf_q   <= ovf_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign full      = fifo_full;
  assign empty     = fifo_empty;
  assign count     = fifo_count;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule
